parity_frame_checker: RTL and testbench
=======================================

Name: parity_frame_checker

Overview:
Receive-side counterpart of the team's XOR-based parity generator. Deserializes a bit-serial frame (start bit, DATA_W data bits LSB first, one parity bit, stop bit) qualified by a per-bit valid strobe. Recomputes parity with a running XOR and checks it against the received parity bit. Reports the recovered word with parity-error and framing-error flags. Sits between the serial link front end and the word-level consumer.

Parameters:
DATA_W, 8, number of data bits per frame (legal range 1..32)
PARITY_ODD, 0, 0 = even parity expected, 1 = odd parity expected

Ports:
clk  input  1  system clock, all state updates on rising edge
rst  input  1  asynchronous, active-high reset
in_valid  input  1  qualifies in_bit this cycle; when low, all state holds
in_bit  input  1  serial line bit
data_out  output  DATA_W  last received data word
data_valid  output  1  one-cycle pulse marking completion of a frame
parity_err  output  1  parity mismatch on the last completed frame
frame_err  output  1  stop bit was 0 on the last completed frame
busy  output  1  high while a frame is in progress (state != IDLE)

Behaviour:
- Reset (async, rst=1):
  - state=IDLE, bit counter=0, running parity=0, shift register=0.
  - data_out=0, data_valid=0, parity_err=0, frame_err=0, busy=0.
- All transitions occur only on rising clk edges with in_valid=1. When in_valid=0, state, counter, parity and shift register hold. data_valid is still forced low on that edge.
- States:
  - IDLE: in_bit=0 (start bit) -> DATA, counter=0, parity=0. in_bit=1 -> stay in IDLE (line idle).
  - DATA: shift in_bit into the MSB of the shift register (right shift, so the first bit ends at bit 0). parity ^= in_bit, counter++. After the DATA_W-th bit -> PARITY.
  - PARITY: store the received parity bit. Compute mismatch = parity ^ in_bit ^ PARITY_ODD (1 = error). -> STOP.
  - STOP: on the edge that samples the stop bit:
    - data_out <= shift register.
    - parity_err <= stored mismatch.
    - frame_err <= ~in_bit.
    - data_valid <= 1.
    - -> IDLE.
- data_valid is registered. It is high for exactly one cycle, in the cycle after the stop-bit sampling edge, then drops on the next edge regardless of in_valid.
- data_valid pulses on every completed frame, including errored ones. parity_err and frame_err qualify that pulse.
- data_out, parity_err and frame_err hold until the next frame completes. They are not cleared at frame start.
- Frame error: no resynchronization hunt. The FSM returns to IDLE, and the next in_bit=0 is treated as a start bit.
- Latency: DATA_W+3 valid bits from start bit to the sampling of the stop bit. data_valid is visible one clock after that edge.
- Back-to-back frames: the start bit of the next frame may be presented on the first in_valid cycle after the stop bit. The FSM is already in IDLE, so no idle bit is required.
- Reset mid-frame: the partial frame is discarded and all outputs return to reset values immediately. No data_valid is generated for the aborted frame.
- busy = (state != IDLE), combinational from state.
- Counter width: clog2(DATA_W+1) bits. There is no wrap; the counter is cleared on every IDLE->DATA transition.

Test Plan:
- Clean frame, even parity: bits 0, 1,0,1,0,0,1,0,1, 0, 1 with in_valid=1 continuously -> one data_valid pulse, data_out=0xA5, parity_err=0, frame_err=0, busy low after stop.
- Parity error: frame for 0x01 with parity bit 0 and stop 1 -> data_out=0x01, parity_err=1, frame_err=0, data_valid pulses once.
- Framing error plus recovery: frame for 0x3C with parity 0 and stop 0 -> frame_err=1, parity_err=0. Then an immediate clean frame for 0xFF (parity 0, stop 1) -> data_out=0xFF, both flags 0.
- Gapped valid: 0xA5 frame with in_valid toggled 1/0 every cycle and garbage on in_bit during in_valid=0 -> same result as the first scenario. data_valid width is 1 cycle.
- Reset mid-frame: assert rst after 4 data bits -> all outputs 0 asynchronously, no data_valid. A following clean 0x5A frame -> data_out=0x5A.
- PARITY_ODD=1 instance: 0x00 with parity bit 1 -> parity_err=0. 0x00 with parity bit 0 -> parity_err=1. Idle in_bit=1 with in_valid=1 for 10 cycles -> busy stays 0.

Source files
------------

// File: rtl/parity_frame_checker_if.sv
// Word-side and serial-side signals of the parity frame checker.
// The checker itself connects through the slave modport.
interface parity_frame_checker_if #(
  parameter int DATA_W = 8
);
  logic              in_valid;
  logic              in_bit;
  logic [DATA_W-1:0] data_out;
  logic              data_valid;
  logic              parity_err;
  logic              frame_err;
  logic              busy;

  modport master (
    output in_valid, in_bit,
    input  data_out, data_valid, parity_err, frame_err, busy
  );

  modport slave (
    input  in_valid, in_bit,
    output data_out, data_valid, parity_err, frame_err, busy
  );
endinterface

// File: rtl/parity_frame_checker.sv
// Deserializes start / DATA_W data bits (LSB first) / parity / stop frames
// and flags parity mismatches and bad stop bits on the recovered word.
//
// state  | meaning
// IDLE   | line idle, waiting for a 0 start bit
// DATA   | shifting in data bits, running XOR parity
// PARITY | sampling the received parity bit
// STOP   | sampling the stop bit, publishing the word
module parity_frame_checker #(
  parameter int DATA_W     = 8,
  parameter int PARITY_ODD = 0
) (
  input  logic                  clk,
  input  logic                  rst,
  parity_frame_checker_if.slave bus
);

  localparam int CNT_W = (DATA_W < 1) ? 1 : $clog2(DATA_W + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DATA_W - 1);
  localparam logic ODD = (PARITY_ODD != 0);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    DATA   = 2'd1,
    PARITY = 2'd2,
    STOP   = 2'd3
  } state_t;

  state_t            state;
  logic [CNT_W-1:0]  cnt;
  logic              par;
  logic              mismatch;
  logic [DATA_W-1:0] shift;
  logic [DATA_W-1:0] shift_next;
  logic [DATA_W-1:0] data_q;
  logic              data_valid_q;
  logic              parity_err_q;
  logic              frame_err_q;

  // Right shift so the first (LSB) data bit lands at bit 0 after DATA_W bits.
  generate
    if (DATA_W == 1) begin : g_shift_one
      assign shift_next = bus.in_bit;
    end else begin : g_shift_many
      assign shift_next = {bus.in_bit, shift[DATA_W-1:1]};
    end
  endgenerate

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= IDLE;
      cnt          <= '0;
      par          <= 1'b0;
      mismatch     <= 1'b0;
      shift        <= '0;
      data_q       <= '0;
      data_valid_q <= 1'b0;
      parity_err_q <= 1'b0;
      frame_err_q  <= 1'b0;
    end else begin
      data_valid_q <= 1'b0;
      if (bus.in_valid) begin
        case (state)
          IDLE: begin
            if (!bus.in_bit) begin
              state <= DATA;
              cnt   <= '0;
              par   <= 1'b0;
            end
          end
          DATA: begin
            shift <= shift_next;
            par   <= par ^ bus.in_bit;
            cnt   <= cnt + 1'b1;
            if (cnt == CNT_LAST) begin
              state <= PARITY;
            end
          end
          PARITY: begin
            mismatch <= par ^ bus.in_bit ^ ODD;
            state    <= STOP;
          end
          STOP: begin
            data_q       <= shift;
            parity_err_q <= mismatch;
            frame_err_q  <= ~bus.in_bit;
            data_valid_q <= 1'b1;
            state        <= IDLE;
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

  assign bus.data_out   = data_q;
  assign bus.data_valid = data_valid_q;
  assign bus.parity_err = parity_err_q;
  assign bus.frame_err  = frame_err_q;
  assign bus.busy       = (state != IDLE);

endmodule

// File: tb/tb_parity_frame_checker.sv
// Directed bench for parity_frame_checker: an even-parity and an odd-parity
// instance driven with hand-built frames.
module tb_parity_frame_checker;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_tests = 0;
  int   n_fail  = 0;
  int   pulses_e = 0;
  int   pulses_o = 0;

  always #5 clk = ~clk;

  parity_frame_checker_if #(.DATA_W(8)) bus_e ();
  parity_frame_checker_if #(.DATA_W(8)) bus_o ();

  parity_frame_checker #(.DATA_W(8), .PARITY_ODD(0)) dut_e (
    .clk (clk),
    .rst (rst),
    .bus (bus_e.slave)
  );

  parity_frame_checker #(.DATA_W(8), .PARITY_ODD(1)) dut_o (
    .clk (clk),
    .rst (rst),
    .bus (bus_o.slave)
  );

  // One sample per clock period, mid-cycle, so each registered pulse counts once.
  always @(negedge clk) begin
    if (bus_e.data_valid) pulses_e++;
    if (bus_o.data_valid) pulses_o++;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic drive(input bit odd, input logic v, input logic b);
    @(negedge clk);
    if (odd) begin
      bus_o.in_valid = v;
      bus_o.in_bit   = b;
    end else begin
      bus_e.in_valid = v;
      bus_e.in_bit   = b;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      bus_e.in_valid = 1'b0;
      bus_o.in_valid = 1'b0;
      @(posedge clk);
      #1;
    end
  endtask

  // Sends start, data LSB first, parity, stop; optional invalid gap cycles with
  // random line values between valid bits. Returns right after the stop edge.
  task automatic send_frame(input bit odd, input logic [7:0] d, input logic p,
                            input logic s, input bit gapped);
    logic [10:0] bits;
    bits = {s, p, d, 1'b0};
    for (int i = 0; i < 11; i++) begin
      if (gapped && i != 0) drive(odd, 1'b0, 1'($urandom_range(0, 1)));
      drive(odd, 1'b1, bits[i]);
    end
  endtask

  task automatic check_result(input string tag, input bit odd, input logic [7:0] d,
                              input logic pe, input logic fe);
    if (odd) begin
      check({tag, "_dv"},   {31'd0, bus_o.data_valid}, 32'd1);
      check({tag, "_data"}, {24'd0, bus_o.data_out},   {24'd0, d});
      check({tag, "_perr"}, {31'd0, bus_o.parity_err}, {31'd0, pe});
      check({tag, "_ferr"}, {31'd0, bus_o.frame_err},  {31'd0, fe});
      check({tag, "_busy"}, {31'd0, bus_o.busy},       32'd0);
    end else begin
      check({tag, "_dv"},   {31'd0, bus_e.data_valid}, 32'd1);
      check({tag, "_data"}, {24'd0, bus_e.data_out},   {24'd0, d});
      check({tag, "_perr"}, {31'd0, bus_e.parity_err}, {31'd0, pe});
      check({tag, "_ferr"}, {31'd0, bus_e.frame_err},  {31'd0, fe});
      check({tag, "_busy"}, {31'd0, bus_e.busy},       32'd0);
    end
  endtask

  task automatic check_zero(input string tag);
    check({tag, "_data"}, {24'd0, bus_e.data_out}, 32'd0);
    check({tag, "_dv"},   {31'd0, bus_e.data_valid}, 32'd0);
    check({tag, "_perr"}, {31'd0, bus_e.parity_err}, 32'd0);
    check({tag, "_ferr"}, {31'd0, bus_e.frame_err}, 32'd0);
    check({tag, "_busy"}, {31'd0, bus_e.busy}, 32'd0);
  endtask

  initial begin
    int p0;
    bus_e.in_valid = 1'b0;
    bus_e.in_bit   = 1'b1;
    bus_o.in_valid = 1'b0;
    bus_o.in_bit   = 1'b1;
    #12;
    check_zero("reset");
    @(negedge clk);
    rst = 1'b0;
    idle(2);

    // Clean 0xA5, four ones -> even parity bit 0
    p0 = pulses_e;
    send_frame(1'b0, 8'hA5, 1'b0, 1'b1, 1'b0);
    check_result("clean_a5", 1'b0, 8'hA5, 1'b0, 1'b0);
    idle(1);
    check("clean_a5_dv_drop", {31'd0, bus_e.data_valid}, 32'd0);
    check("clean_a5_pulses", 32'(pulses_e - p0), 32'd1);

    // 0x01 needs parity 1; sending 0 is a parity error
    p0 = pulses_e;
    send_frame(1'b0, 8'h01, 1'b0, 1'b1, 1'b0);
    check_result("perr_01", 1'b0, 8'h01, 1'b1, 1'b0);
    idle(1);
    check("perr_01_pulses", 32'(pulses_e - p0), 32'd1);

    // Bad stop bit, then immediate back-to-back clean frame
    send_frame(1'b0, 8'h3C, 1'b0, 1'b0, 1'b0);
    check_result("ferr_3c", 1'b0, 8'h3C, 1'b0, 1'b1);
    send_frame(1'b0, 8'hFF, 1'b0, 1'b1, 1'b0);
    check_result("recov_ff", 1'b0, 8'hFF, 1'b0, 1'b0);
    idle(1);

    // Gapped valid with garbage between bits
    p0 = pulses_e;
    send_frame(1'b0, 8'hA5, 1'b0, 1'b1, 1'b1);
    check_result("gap_a5", 1'b0, 8'hA5, 1'b0, 1'b0);
    idle(3);
    check("gap_a5_pulses", 32'(pulses_e - p0), 32'd1);

    // Reset mid-frame: start plus 4 data bits, then async reset between edges
    p0 = pulses_e;
    drive(1'b0, 1'b1, 1'b0);
    for (int i = 0; i < 4; i++) drive(1'b0, 1'b1, 1'(i & 1));
    check("mid_busy", {31'd0, bus_e.busy}, 32'd1);
    check("mid_hold_data", {24'd0, bus_e.data_out}, 32'h000000A5);
    #1;
    rst = 1'b1;
    #1;
    check_zero("mid_rst");
    @(negedge clk);
    bus_e.in_valid = 1'b0;
    rst = 1'b0;
    idle(2);
    check("mid_rst_pulses", 32'(pulses_e - p0), 32'd0);
    send_frame(1'b0, 8'h5A, 1'b0, 1'b1, 1'b0);
    check_result("after_rst_5a", 1'b0, 8'h5A, 1'b0, 1'b0);
    idle(1);

    // Odd-parity instance
    send_frame(1'b1, 8'h00, 1'b1, 1'b1, 1'b0);
    check_result("odd_ok", 1'b1, 8'h00, 1'b0, 1'b0);
    send_frame(1'b1, 8'h00, 1'b0, 1'b1, 1'b0);
    check_result("odd_err", 1'b1, 8'h00, 1'b1, 1'b0);
    for (int i = 0; i < 10; i++) begin
      drive(1'b1, 1'b1, 1'b1);
      check("odd_idle_busy", {31'd0, bus_o.busy}, 32'd0);
    end
    check("odd_pulses", 32'(pulses_o), 32'd2);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not complete, expected completion");
    $fatal(1);
  end

endmodule
